// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write-port bundle for instr_encoder.
// slave is the encoder's view; master is the loader/memory side.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [2:0]        in_alucontrol;
    logic              in_store;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;
    logic              wr_ack;

    modport master (
        output in_valid, in_kind, in_alucontrol, in_store, in_rs, in_rt, in_rd, in_imm,
        input  in_ready,
        input  we, wa, wd,
        output wr_ack
    );

    modport slave (
        input  in_valid, in_kind, in_alucontrol, in_store, in_rs, in_rt, in_rd, in_imm,
        output in_ready,
        output we, wa, wd,
        input  wr_ack
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes alucontrol-level requests into MIPS words and streams them through a
// small FIFO into the instruction-memory write port.
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    instr_encoder_if.slave      bus,
    output logic                err,
    output logic                wrapped
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE_WA  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_WA  = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    // Returns {legal, word}; the word is meaningless when legal is 0.
    function automatic logic [32:0] encode(
        input logic [1:0]  kind,
        input logic [2:0]  alu,
        input logic        st,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [5:0] op;
        logic [5:0] funct;
        logic       ok;
        op    = 6'b000000;
        funct = 6'b000000;
        ok    = 1'b1;
        case (kind)
            2'b00: begin
                case (alu)
                    3'b010:  funct = 6'b100000;
                    3'b110:  funct = 6'b100010;
                    3'b000:  funct = 6'b100100;
                    3'b001:  funct = 6'b100101;
                    3'b111:  funct = 6'b101010;
                    default: ok = 1'b0;
                endcase
            end
            2'b01: begin
                op = st ? 6'b101011 : 6'b100011;
                ok = (alu == 3'b010);
            end
            2'b10: begin
                op = 6'b000100;
                ok = (alu == 3'b110);
            end
            2'b11: begin
                case (alu)
                    3'b010:  op = 6'b001000;
                    3'b001:  op = 6'b001101;
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
        if (kind == 2'b00) begin
            return {ok, op, rs, rt, rd, 5'b00000, funct};
        end else begin
            return {ok, op, rs, rt, imm};
        end
    endfunction

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic              err_q, err_d, wrapped_q, wrapped_d;
    logic [32:0]       enc_s;
    logic              full_s, empty_s, accept_s, push_s, pop_s;

    // Handshake, encoding and output view of the registered FIFO head.
    always_comb begin
        enc_s        = encode(bus.in_kind, bus.in_alucontrol, bus.in_store,
                              bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
        full_s       = (count_q == FULL_CNT);
        empty_s      = (count_q == {CNT_W{1'b0}});
        bus.in_ready = reset & ~full_s & ~clear;
        accept_s     = bus.in_valid & bus.in_ready;
        push_s       = accept_s & enc_s[32];
        pop_s        = ~empty_s & bus.wr_ack & ~clear;
        bus.we       = ~empty_s;
        bus.wd       = empty_s ? 32'h0000_0000 : mem_q[rd_ptr_q];
        bus.wa       = wa_q;
        err          = err_q;
        wrapped      = wrapped_q;
    end

    // Next-state: clear overrides push, pop and the sticky flags.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wa_d      = wa_q;
        err_d     = err_q;
        wrapped_d = wrapped_q;
        if (clear) begin
            wr_ptr_d  = {PTR_W{1'b0}};
            rd_ptr_d  = {PTR_W{1'b0}};
            count_d   = {CNT_W{1'b0}};
            wa_d      = BASE_WA;
            err_d     = 1'b0;
            wrapped_d = 1'b0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = enc_s[31:0];
                wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1'b1);
                wa_d      = wa_q + ADDR_W'(1'b1);
                wrapped_d = wrapped_q | (wa_q == LAST_WA);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
            err_d = err_q | (accept_s & ~enc_s[32]);
        end
    end

    // State registers; asynchronous reset discards any buffered words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            wa_q      <= BASE_WA;
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wa_q      <= wa_d;
            err_q     <= err_d;
            wrapped_q <= wrapped_d;
        end
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes ALU-level operation requests (instruction kind, 3-bit alucontrol, register fields, immediate) into 32-bit MIPS machine words and streams them into the instruction-memory write port. It is the inverse of the control-path ALU decode: the test/boot loader uses it to build programs for the pipelined core from the same alucontrol encoding the datapath consumes. A small FIFO decouples request acceptance from memory write acknowledgement.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- ADDR_W, 6, instruction-memory word-address width
- BASE_ADDR, 0, first write address after reset/clear
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush: empties FIFO, restores address, clears flags
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_kind  in  2  00 R-type, 01 load/store, 10 branch, 11 immediate
- in_alucontrol  in  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- in_store  in  1  kind 01 only: 1 = sw, 0 = lw
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- we  out  1  write request to instruction memory
- wa  out  ADDR_W  word address of write
- wd  out  32  encoded instruction
- wr_ack  in  1  memory accepted the write this cycle
- err  out  1  sticky: an illegal request was dropped
- wrapped  out  1  sticky: write address wrapped to 0

## Operation
- Encoding, combinational from request fields:
  - R-type: {000000, rs, rt, rd, 00000, funct}; funct per alucontrol: 010→100000, 110→100010, 000→100100, 001→100101, 111→101010.
  - Load/store: alucontrol must be 010; opcode 100011 (lw) or 101011 (sw); {op, rs, rt, imm}.
  - Branch: alucontrol must be 110; {000100, rs, rt, imm} (beq).
  - Immediate: 010→001000 (addi), 001→001101 (ori); {op, rs, rt, imm}.
  - Any other kind/alucontrol pair is illegal; in_rd is ignored for non-R-type.
- Accepted legal request: encoded word pushed into FIFO tail.
- Accepted illegal request: consumed (handshake completes), not pushed, err set to 1.
- in_ready = !full && !clear; no bypass path, so no push into a full FIFO even if it pops the same cycle.
- we = !empty; wd = FIFO head; wa = address counter.
- we && wr_ack: pop head; wa increments modulo 2^ADDR_W; on transition from 2^ADDR_W-1 to 0, wrapped set to 1.
- Push and pop in the same cycle (non-full, non-empty): occupancy unchanged, order preserved.
- clear has priority over push, pop, and flags: FIFO emptied, wa = BASE_ADDR, err = 0, wrapped = 0; wr_ack is ignored that cycle.

## Timing
- Reset (reset = 0, asynchronous): FIFO empty, we = 0, wd = 0, wa = BASE_ADDR, err = 0, wrapped = 0, in_ready = 0 while asserted; in_ready = 1 from the first cycle after deassertion.
- Latency: request accepted at edge N → we = 1 with that word from cycle N+1 (registered FIFO).
- Throughput: one word per cycle with wr_ack held high.
- While we = 1 and wr_ack = 0, wa and wd are held stable.
- err is visible the cycle after the offending accept.
- wrapped is visible the cycle after the wrapping ack.
- Reset asserted mid-stream: buffered words are discarded; no partial write survives.

## Test plan
- R-type add, rs=1, rt=2, rd=3, wr_ack=1 → one cycle later we=1, wa=0, wd=0x00221820; err stays 0.
- Stream lw(rs=29,rt=8,imm=4), sw(rs=29,rt=8,imm=8), ori(rs=0,rt=5,imm=0x00FF), beq(rs=1,rt=2,imm=0xFFFE) back-to-back with wr_ack=1 → wd = 0x8FA80004, 0xAFA80008, 0x340500FF, 0x1022FFFE at wa = 0, 1, 2, 3 on consecutive cycles.
- R-type with alucontrol=011, then branch with alucontrol=010 → both consumed, no we, err=1; a following legal add is still written at wa=0.
- DEPTH=4, wr_ack=0, present 5 requests → in_ready drops after the 4th accept; we held with first word and wa=0 stable; raising wr_ack drains all 5 in order.
- ADDR_W=2, 5 legal writes → wa = 0, 1, 2, 3, 0; wrapped=1 after the 4th ack. Then pulse clear → wa=BASE_ADDR, wrapped=0, err=0, FIFO empty.
- Assert reset with 3 words buffered → we=0 and wa=BASE_ADDR immediately (asynchronously); nothing is written after release until a new request is accepted.
